// File: rtl/fft_coeff_pkg.sv
// rtl/fft_coeff_pkg.sv - shared constants, state type and field helpers for the coefficient reader
package fft_coeff_pkg;

    localparam int NBITS_DEF = 11;
    localparam int N_DEF     = 32;
    localparam int ENTRY_W   = 2 * NBITS_DEF;
    localparam int BUS_W     = N_DEF * ENTRY_W;

    // Q1.9 reference points
    localparam logic signed [NBITS_DEF-1:0] ONE       = 11'sd512;
    localparam logic signed [NBITS_DEF-1:0] MINUS_ONE = -11'sd512;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Real field of entry k (upper half of the entry)
    function automatic logic [NBITS_DEF-1:0] coeff_re_of(input logic [BUS_W-1:0] bus,
                                                          input int unsigned k);
        return bus[k*ENTRY_W + NBITS_DEF +: NBITS_DEF];
    endfunction

    // Imag field of entry k (lower half of the entry)
    function automatic logic [NBITS_DEF-1:0] coeff_im_of(input logic [BUS_W-1:0] bus,
                                                          input int unsigned k);
        return bus[k*ENTRY_W +: NBITS_DEF];
    endfunction

    // Two's-complement negate; the most negative code has no positive twin so it clamps
    function automatic logic [NBITS_DEF-1:0] sat_neg(input logic [NBITS_DEF-1:0] x);
        if (x == {1'b1, {(NBITS_DEF-1){1'b0}}})
            return {1'b0, {(NBITS_DEF-1){1'b1}}};
        else
            return ~x + NBITS_DEF'(1);
    endfunction

endpackage

// File: rtl/coeff_unpack.sv
// rtl/coeff_unpack.sv - selects entry k from a packed bus and applies optional saturating conjugation
module coeff_unpack #(
    parameter int NBITS = 11,
    parameter int N     = 32,
    parameter int IW    = 5
) (
    input  logic [NBITS*N*2-1:0] bus,
    input  logic [IW-1:0]        idx,
    input  logic                 conj,
    output logic [NBITS-1:0]     re,
    output logic [NBITS-1:0]     im
);

    localparam int EW = 2 * NBITS;
    localparam logic [NBITS-1:0] MIN_CODE = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [NBITS-1:0] MAX_CODE = {1'b0, {(NBITS-1){1'b1}}};

    logic [EW-1:0]    entry;
    logic [NBITS-1:0] im_raw;

    // Entry mux followed by the conj path; negating the most negative code clamps to max
    always_comb begin
        entry  = bus[idx*EW +: EW];
        re     = entry[EW-1:NBITS];
        im_raw = entry[NBITS-1:0];
        im     = im_raw;
        if (conj) begin
            if (im_raw == MIN_CODE)
                im = MAX_CODE;
            else
                im = ~im_raw + NBITS'(1);
        end
    end

endmodule

// File: rtl/coeff_stream_reader.sv
// rtl/coeff_stream_reader.sv - snapshots the packed coefficient bus and streams it for a number of frames
module coeff_stream_reader
    import fft_coeff_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int N     = N_DEF,
    parameter int FW    = 8,
    parameter int IW    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NBITS*N*2-1:0] coeff_data,
    input  logic                 start,
    input  logic [FW-1:0]        frames,
    input  logic                 conj,
    output logic                 busy,
    output logic                 coeff_valid,
    input  logic                 coeff_ready,
    output logic [NBITS-1:0]     coeff_re,
    output logic [NBITS-1:0]     coeff_im,
    output logic [IW-1:0]        coeff_idx,
    output logic                 coeff_last,
    output logic                 frame_last,
    output logic                 done
);

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    state_t              state;
    logic [NBITS*N*2-1:0] shadow;
    logic [FW-1:0]        frames_q;
    logic                 conj_q;
    logic [FW-1:0]        frame_cnt;

    logic                 xfer;
    logic                 last_beat;
    logic                 final_frame;
    logic [NBITS*N*2-1:0] sel_bus;
    logic                 sel_conj;
    logic [IW-1:0]        sel_idx;
    logic [FW-1:0]        nxt_frame;
    logic [NBITS-1:0]     nxt_re;
    logic [NBITS-1:0]     nxt_im;

    assign xfer        = coeff_valid && coeff_ready;
    assign last_beat   = (coeff_idx == IDX_LAST);
    assign final_frame = (frame_cnt == frames_q - FW'(1));

    // Pick the bus/index/conj that the output registers load next: the live bus when
    // capturing a start, otherwise the shadow copy at the advancing index
    always_comb begin
        sel_bus   = shadow;
        sel_conj  = conj_q;
        sel_idx   = coeff_idx;
        nxt_frame = frame_cnt;
        if (state == ST_IDLE) begin
            sel_bus  = coeff_data;
            sel_conj = conj;
            sel_idx  = '0;
        end else if (xfer) begin
            if (last_beat) begin
                sel_idx   = '0;
                nxt_frame = frame_cnt + FW'(1);
            end else begin
                sel_idx = coeff_idx + IW'(1);
            end
        end
    end

    coeff_unpack #(
        .NBITS (NBITS),
        .N     (N),
        .IW    (IW)
    ) u_unpack (
        .bus  (sel_bus),
        .idx  (sel_idx),
        .conj (sel_conj),
        .re   (nxt_re),
        .im   (nxt_im)
    );

    // Control FSM with registered beat fields; fields only move on a transfer so a stalled beat holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            shadow      <= '0;
            frames_q    <= '0;
            conj_q      <= 1'b0;
            frame_cnt   <= '0;
            busy        <= 1'b0;
            coeff_valid <= 1'b0;
            coeff_re    <= '0;
            coeff_im    <= '0;
            coeff_idx   <= '0;
            coeff_last  <= 1'b0;
            frame_last  <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shadow    <= coeff_data;
                        frames_q  <= frames;
                        conj_q    <= conj;
                        frame_cnt <= '0;
                        coeff_idx <= '0;
                        if (frames != '0) begin
                            state       <= ST_STREAM;
                            busy        <= 1'b1;
                            coeff_valid <= 1'b1;
                            coeff_re    <= nxt_re;
                            coeff_im    <= nxt_im;
                            coeff_last  <= (N == 1);
                            frame_last  <= (N == 1) && (frames == FW'(1));
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        if (last_beat && final_frame) begin
                            state       <= ST_DONE;
                            busy        <= 1'b0;
                            coeff_valid <= 1'b0;
                            coeff_last  <= 1'b0;
                            frame_last  <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            coeff_idx  <= sel_idx;
                            frame_cnt  <= nxt_frame;
                            coeff_re   <= nxt_re;
                            coeff_im   <= nxt_im;
                            coeff_last <= (sel_idx == IDX_LAST);
                            frame_last <= (sel_idx == IDX_LAST) &&
                                          (nxt_frame == frames_q - FW'(1));
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_stream_reader.sv
// tb/tb_coeff_stream_reader.sv - scoreboard bench for coeff_stream_reader
module tb_coeff_stream_reader;

    localparam int NBITS = 11;
    localparam int N     = 32;
    localparam int FW    = 8;
    localparam int IW    = 5;
    localparam int BW    = NBITS * N * 2;

    logic              clk;
    logic              rst;
    logic [BW-1:0]     coeff_data;
    logic              start;
    logic [FW-1:0]     frames_in;
    logic              conj_in;
    logic              busy;
    logic              coeff_valid;
    logic              coeff_ready;
    logic [NBITS-1:0]  coeff_re;
    logic [NBITS-1:0]  coeff_im;
    logic [IW-1:0]     coeff_idx;
    logic              coeff_last;
    logic              frame_last;
    logic              done;

    coeff_stream_reader #(.NBITS(NBITS), .N(N), .FW(FW), .IW(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .coeff_data  (coeff_data),
        .start       (start),
        .frames      (frames_in),
        .conj        (conj_in),
        .busy        (busy),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .coeff_re    (coeff_re),
        .coeff_im    (coeff_im),
        .coeff_idx   (coeff_idx),
        .coeff_last  (coeff_last),
        .frame_last  (frame_last),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NBITS-1:0] re;
        logic [NBITS-1:0] im;
        logic [IW-1:0]    idx;
        logic             last;
        logic             flast;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_pop_cyc = -1;
    int    done_count = 0;
    int    exp_done = 0;
    int    ready_pct = 100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: every frame walks all N entries; fields come from signed integer arithmetic
    task automatic push_job(input logic [BW-1:0] bus, input int nframes, input bit cj);
        beat_t b;
        int r;
        int im;
        logic [NBITS-1:0] fr;
        logic [NBITS-1:0] fi;
        for (int f = 0; f < nframes; f++) begin
            for (int k = 0; k < N; k++) begin
                fr = bus[k*2*NBITS + NBITS +: NBITS];
                fi = bus[k*2*NBITS +: NBITS];
                r  = $signed(fr);
                im = $signed(fi);
                if (cj) begin
                    im = -im;
                    if (im > (1 << (NBITS-1)) - 1) im = (1 << (NBITS-1)) - 1;
                end
                b.re    = r[NBITS-1:0];
                b.im    = im[NBITS-1:0];
                b.idx   = k[IW-1:0];
                b.last  = (k == N-1);
                b.flast = (k == N-1) && (f == nframes-1);
                exp_q.push_back(b);
            end
        end
    endtask

    function automatic logic [BW-1:0] rand_bus();
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < BW; i += 32) b[i +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [BW-1:0] std_bus();
        logic [BW-1:0] b;
        int re_v;
        int im_v;
        b = '0;
        for (int k = 0; k < N; k++) begin
            re_v = (k < 16) ? 0 : 512;
            im_v = (k < 16) ? -512 : 0;
            b[k*2*NBITS + NBITS +: NBITS] = re_v[NBITS-1:0];
            b[k*2*NBITS +: NBITS]         = im_v[NBITS-1:0];
        end
        return b;
    endfunction

    // Ready generator: new random level shortly after each rising edge
    initial begin
        coeff_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            coeff_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: pops one expected beat per handshake, checks stall stability and done timing
    initial begin
        logic [29:0] prev_fields;
        bit          have_prev;
        bit          prev_stall;
        bit          prev_done;
        beat_t       e;
        have_prev  = 0;
        prev_stall = 0;
        prev_done  = 0;
        prev_fields = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                have_prev = 0;
                prev_done = 0;
            end else begin
                if (have_prev && prev_stall)
                    chk("stall_hold",
                        {coeff_valid, coeff_re, coeff_im, coeff_idx, coeff_last, frame_last},
                        prev_fields);
                if (coeff_valid && coeff_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat idx=%0d re=%0h im=%0h expected=none",
                                 coeff_idx, coeff_re, coeff_im);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {coeff_re, coeff_im, coeff_idx, coeff_last, frame_last},
                            {e.re, e.im, e.idx, e.last, e.flast});
                        if (exp_q.size() == 0) last_pop_cyc = cyc;
                    end
                end
                if (done) begin
                    done_count++;
                    chk("done_q_empty", exp_q.size(), 0);
                    chk("done_valid_low", {coeff_valid, busy}, 2'b00);
                    chk("done_width", prev_done, 0);
                    if (last_pop_cyc >= 0) chk("done_latency", cyc, last_pop_cyc + 1);
                    last_pop_cyc = -1;
                end
                prev_fields = {coeff_valid, coeff_re, coeff_im, coeff_idx, coeff_last, frame_last};
                prev_stall  = coeff_valid && !coeff_ready;
                prev_done   = done;
                have_prev   = 1;
            end
        end
    end

    task automatic launch(input logic [BW-1:0] bus, input int nframes, input bit cj);
        @(posedge clk);
        #1;
        coeff_data = bus;
        frames_in  = nframes[FW-1:0];
        conj_in    = cj;
        start      = 1'b1;
        push_job(bus, nframes, cj);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done within %0d cycles", budget);
        end
    endtask

    task automatic run_job(input logic [BW-1:0] bus, input int nframes, input bit cj,
                           input bit poke_busy, input bit scramble);
        launch(bus, nframes, cj);
        exp_done++;
        if (scramble) coeff_data = rand_bus();
        if (poke_busy) begin
            repeat (10) @(posedge clk);
            #1;
            frames_in = 8'd5;
            start     = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(nframes * N * 8 + 40);
    endtask

    initial begin
        logic [BW-1:0] b;
        bit hit;
        rst        = 1'b1;
        start      = 1'b0;
        coeff_data = '0;
        frames_in  = '0;
        conj_in    = 1'b0;

        #12;
        chk("rst_fields", {coeff_re, coeff_im, coeff_idx}, 0);
        chk("rst_ctrl", {busy, coeff_valid, coeff_last, frame_last, done}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Standard bus, one frame, ready always high
        ready_pct = 100;
        run_job(std_bus(), 1, 1'b0, 1'b0, 1'b0);

        // Standard bus conjugated over three frames; start poked while busy
        run_job(std_bus(), 3, 1'b1, 1'b1, 1'b0);

        // Random bus, two frames, ~40% ready, bus scrambled after capture
        ready_pct = 40;
        run_job(rand_bus(), 2, $urandom_range(1), 1'b0, 1'b1);

        // Saturation: several entries at the most negative imag code, conj on
        ready_pct = 70;
        b = rand_bus();
        b[5*2*NBITS +: NBITS]  = 11'h400;
        b[9*2*NBITS +: NBITS]  = 11'h400;
        b[31*2*NBITS +: NBITS] = 11'h400;
        run_job(b, 1, 1'b1, 1'b0, 1'b0);

        // Start presented during the done cycle must be ignored
        start      = 1'b1;
        frames_in  = 8'd1;
        coeff_data = rand_bus();
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("start_in_done_ignored", {busy, coeff_valid}, 2'b00);
        end

        // Zero frames: done pulse with no beats
        run_job(rand_bus(), 0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame at idx 7
        ready_pct = 100;
        launch(rand_bus(), 2, 1'b0);
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (coeff_valid && coeff_idx == 5'd7) begin
                hit = 1;
                break;
            end
        end
        chk("reach_idx7", hit, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_fields", {coeff_re, coeff_im, coeff_idx}, 0);
        chk("async_rst_ctrl", {busy, coeff_valid, coeff_last, frame_last, done}, 0);
        exp_q.delete();
        last_pop_cyc = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {busy, coeff_valid, done}, 0);

        // Restart after reset begins again from idx 0
        ready_pct = 60;
        run_job(rand_bus(), 1, $urandom_range(1), 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("final_q_empty", exp_q.size(), 0);
        chk("done_count", done_count, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
